// File: rtl/fir_sample_ram.sv
// Dual-port byte-enabled sample RAM with optional zero-fill after reset,
// cross-port write forwarding on reads and same-address dual-write collision tracking.
module fir_sample_ram #(
   parameter int DATA_W         = 64,
   parameter int ADDR_W         = 14,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic                clk,
   input  logic                reset,
   // Port A
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [DATA_W-1:0]   writedata,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid,
   output logic                waitrequest,
   // Port B
   input  logic [ADDR_W-1:0]   address2,
   input  logic [DATA_W/8-1:0] byteenable2,
   input  logic                chipselect2,
   input  logic                read2,
   input  logic                write2,
   input  logic [DATA_W-1:0]   writedata2,
   output logic [DATA_W-1:0]   readdata2,
   output logic                readdatavalid2,
   output logic                waitrequest2,
   // Status
   output logic                init_busy,
   output logic                collision,
   output logic [CNT_W-1:0]    collision_count
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          clear_addr_q, clear_addr_d;
   logic [DATA_W-1:0]          mem_q [DEPTH];

   logic                       ready;
   logic                       clear_we;
   logic                       wr_a, wr_b;
   logic [1:0]                 rd_acc;
   logic                       collide;
   logic [NB-1:0]              be_b_eff;
   logic [1:0][DATA_W-1:0]     fwd;
   logic [1:0]                 src_v;
   logic [1:0][DATA_W-1:0]     src_d;
   logic [1:0]                 rv_q;
   logic [1:0][DATA_W-1:0]     rdo_q;
   logic                       coll_q;
   logic [CNT_W-1:0]           cnt_q;

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     be);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      clear_addr_d = clear_addr_q;
      if (state_q == CLEAR) begin
         if (!CLEAR_ON_RESET || (&clear_addr_q)) state_d = READY;
         else                                    clear_addr_d = clear_addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= CLEAR;
         clear_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
      end
   end

   assign ready        = (state_q == READY);
   assign waitrequest  = ~ready;
   assign waitrequest2 = ~ready;
   assign init_busy    = ~ready;
   assign clear_we     = (state_q == CLEAR) && CLEAR_ON_RESET && !reset;

   // A write on a port wins over a simultaneous read on that same port.
   assign wr_a      = ready & chipselect  & write;
   assign wr_b      = ready & chipselect2 & write2;
   assign rd_acc[0] = ready & chipselect  & read  & ~write;
   assign rd_acc[1] = ready & chipselect2 & read2 & ~write2;

   // On a same-address dual write, port A owns every byte it enables.
   assign collide  = wr_a & wr_b & (address == address2);
   assign be_b_eff = byteenable2 & ~({NB{collide}} & byteenable);

   always_comb begin
      fwd[0] = mem_q[address];
      fwd[1] = mem_q[address2];
      if (wr_b && (address2 == address)) fwd[0] = merge_bytes(fwd[0], writedata2, be_b_eff);
      if (wr_a && (address == address2)) fwd[1] = merge_bytes(fwd[1], writedata, byteenable);
   end

   // NOTE: the array has no reset branch; zero-fill is done by the CLEAR sweep instead.
   always_ff @(posedge clk) begin
      if (clear_we) mem_q[clear_addr_q] <= '0;
      for (int i = 0; i < NB; i++) begin
         if (wr_a && byteenable[i]) mem_q[address][8*i +: 8]  <= writedata[8*i +: 8];
         if (wr_b && be_b_eff[i])   mem_q[address2][8*i +: 8] <= writedata2[8*i +: 8];
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [1:0]             rv1_q;
         logic [1:0][DATA_W-1:0] rd1_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               rv1_q <= '0;
               rd1_q <= '0;
            end else begin
               rv1_q <= rd_acc;
               for (int p = 0; p < 2; p++) begin
                  if (rd_acc[p]) rd1_q[p] <= fwd[p];
               end
            end
         end

         assign src_v = rv1_q;
         assign src_d = rd1_q;
      end else begin : g_lat1
         assign src_v = rd_acc;
         assign src_d = fwd;
      end
   endgenerate

   // Output data only moves on a returning read, so it holds between returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         rv_q  <= '0;
         rdo_q <= '0;
      end else begin
         rv_q <= src_v;
         for (int p = 0; p < 2; p++) begin
            if (src_v[p]) rdo_q[p] <= src_d[p];
         end
      end
   end

   assign readdatavalid  = rv_q[0];
   assign readdatavalid2 = rv_q[1];
   assign readdata       = rdo_q[0];
   assign readdata2      = rdo_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         coll_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         coll_q <= collide;
         if (collide && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign collision       = coll_q;
   assign collision_count = cnt_q;

endmodule

// File: tb/tb_fir_sample_ram.sv
// Directed bench for fir_sample_ram: two instances (read latency 1 and 2) share stimulus,
// read returns are scored against a queue filled from a bench-side memory model.
module tb_fir_sample_ram;

   localparam int AW = 4;
   localparam int DW = 64;
   localparam int BW = DW / 8;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] address = '0, address2 = '0;
   logic [BW-1:0] byteenable = '0, byteenable2 = '0;
   logic          chipselect = 1'b0, read = 1'b0, write = 1'b0;
   logic          chipselect2 = 1'b0, read2 = 1'b0, write2 = 1'b0;
   logic [DW-1:0] writedata = '0, writedata2 = '0;

   logic [DW-1:0] rd_l1, rd2_l1, rd_l2, rd2_l2;
   logic          rdv_l1, rdv2_l1, rdv_l2, rdv2_l2;
   logic          wr_l1, wr2_l1, wr_l2, wr2_l2;
   logic          busy_l1, busy_l2, coll_l1, coll_l2;
   logic [CW-1:0] cnt_l1, cnt_l2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int            port;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] model [16];

   fir_sample_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .CNT_W(CW)) u_l1 (
      .clk(clk), .reset(reset),
      .address(address), .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
      .writedata(writedata), .readdata(rd_l1), .readdatavalid(rdv_l1), .waitrequest(wr_l1),
      .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .read2(read2),
      .write2(write2), .writedata2(writedata2), .readdata2(rd2_l1), .readdatavalid2(rdv2_l1),
      .waitrequest2(wr2_l1), .init_busy(busy_l1), .collision(coll_l1), .collision_count(cnt_l1)
   );

   fir_sample_ram #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1), .CNT_W(CW)) u_l2 (
      .clk(clk), .reset(reset),
      .address(address), .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
      .writedata(writedata), .readdata(rd_l2), .readdatavalid(rdv_l2), .waitrequest(wr_l2),
      .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .read2(read2),
      .write2(write2), .writedata2(writedata2), .readdata2(rd2_l2), .readdatavalid2(rdv2_l2),
      .waitrequest2(wr2_l2), .init_busy(busy_l2), .collision(coll_l2), .collision_count(cnt_l2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every returned read must match the oldest pending entry of its port.
   always @(negedge clk) begin : mon
      logic [3:0]    v;
      logic [DW-1:0] d [4];
      int            idx;
      v    = {rdv2_l2, rdv_l2, rdv2_l1, rdv_l1};
      d[0] = rd_l1;
      d[1] = rd2_l1;
      d[2] = rd_l2;
      d[3] = rd2_l2;
      if (cyc > 0) begin
         for (int p = 0; p < 4; p++) begin
            if (v[p] !== 1'b0) begin
               idx = -1;
               for (int i = 0; i < sb.size(); i++) begin
                  if (idx < 0 && sb[i].port == p) idx = i;
               end
               if (idx < 0) begin
                  check($sformatf("unexpected_rdv_p%0d", p), DW'(v[p]), '0);
               end else begin
                  check($sformatf("rdata_p%0d", p), d[p], sb[idx].data);
                  check($sformatf("rlat_p%0d", p), DW'(cyc), DW'(sb[idx].due));
                  sb.delete(idx);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input bit wa, input bit ra, input logic [AW-1:0] aa, input logic [BW-1:0] bea,
                     input logic [DW-1:0] da,
                     input bit wb, input bit rb, input logic [AW-1:0] ab, input logic [BW-1:0] beb,
                     input logic [DW-1:0] db);
      for (int i = 0; i < BW; i++) begin
         if (wa && bea[i]) model[aa][8*i +: 8] = da[8*i +: 8];
         if (wb && beb[i] && !(wa && aa == ab && bea[i])) model[ab][8*i +: 8] = db[8*i +: 8];
      end
      if (ra && !wa) begin
         sb.push_back(exp_t'{port: 0, data: model[aa], due: cyc + 1});
         sb.push_back(exp_t'{port: 2, data: model[aa], due: cyc + 2});
      end
      if (rb && !wb) begin
         sb.push_back(exp_t'{port: 1, data: model[ab], due: cyc + 1});
         sb.push_back(exp_t'{port: 3, data: model[ab], due: cyc + 2});
      end
      chipselect = wa | ra; read = ra; write = wa; address = aa; byteenable = bea; writedata = da;
      chipselect2 = wb | rb; read2 = rb; write2 = wb; address2 = ab; byteenable2 = beb; writedata2 = db;
      step();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
      chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
   endtask

   task automatic wr_a(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
      op(1, 0, a, be, d, 0, 0, '0, '0, '0);
   endtask

   task automatic rd_a(input logic [AW-1:0] a);
      op(0, 1, a, '0, '0, 0, 0, '0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic wait_clear(output int n1, output int n2);
      n1 = 0;
      n2 = 0;
      for (int i = 0; i < 100; i++) begin
         if (wr_l1)  n1++;
         if (wr2_l2) n2++;
         if (!wr_l1 && !wr2_l2) break;
         step();
      end
      foreach (model[i]) model[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int n1, n2;
      foreach (model[i]) model[i] = '0;

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      check("rst_waitrequest", DW'(wr_l1), 1);
      check("rst_init_busy", DW'(busy_l1), 1);
      check("rst_rdv", DW'({rdv_l1, rdv2_l1, rdv_l2, rdv2_l2}), 0);
      check("rst_readdata", rd_l1 | rd2_l2, 0);
      check("rst_collision", DW'({coll_l1, cnt_l1}), 0);

      // Clear takes exactly DEPTH cycles
      reset = 1'b0;
      wait_clear(n1, n2);
      check("clear_cycles_l1", DW'(n1), 16);
      check("clear_cycles_l2", DW'(n2), 16);
      check("ready_init_busy", DW'({busy_l1, busy_l2}), 0);

      // Cleared word read, dual read in the same cycle
      op(0, 1, 4'd5, '0, '0, 0, 1, 4'd6, '0, '0);

      // Byte-enable write, then readdata hold
      wr_a(4'd3, 8'h0F, 64'h1122334455667788);
      rd_a(4'd3);
      repeat (3) step();
      check("hold_rdv", DW'({rdv_l1, rdv_l2}), 0);
      check("hold_data_l1", rd_l1, 64'h0000000055667788);
      check("hold_data_l2", rd_l2, 64'h0000000055667788);

      // Mixed-port forwarding, full and partial
      op(1, 0, 4'd7, 8'hFF, {8{8'hAA}}, 0, 1, 4'd7, '0, '0);
      op(0, 1, 4'd7, '0, '0, 1, 0, 4'd7, 8'h0F, {8{8'hBB}});
      rd_a(4'd7);

      // Read+write on one port: write wins, no return
      op(1, 1, 4'd2, 8'hFF, 64'hCAFEF00D12345678, 0, 0, '0, '0, '0);
      check("rw_no_rdv_l1", DW'(rdv_l1), 0);
      step();
      check("rw_no_rdv_l2", DW'(rdv_l2), 0);

      // Write without chipselect is ignored
      chipselect = 1'b0; write = 1'b1; address = 4'd2; byteenable = 8'hFF; writedata = 64'hDEAD;
      step();
      write = 1'b0;
      rd_a(4'd2);

      // Same-address dual write collision
      op(1, 0, 4'd9, 8'hF0, {8{8'h11}}, 1, 0, 4'd9, 8'hFF, {8{8'h22}});
      check("coll_pulse", DW'({coll_l1, coll_l2}), 2'b11);
      check("coll_count", DW'(cnt_l1), 1);
      step();
      check("coll_pulse_end", DW'(coll_l1), 0);
      rd_a(4'd9);
      op(1, 0, 4'd10, 8'hFF, 64'hA10, 1, 0, 4'd11, 8'hFF, 64'hB11);
      check("diff_addr_no_coll", DW'({coll_l1, cnt_l1}), 1);
      op(0, 1, 4'd10, '0, '0, 0, 1, 4'd11, '0, '0);

      // Back-to-back reads: latency and ordering checked by the scoreboard
      for (int i = 0; i < 4; i++) wr_a(AW'(i), 8'hFF, 64'h0100_0000_0000_0000 * (i + 1) + 64'(i));
      for (int i = 0; i < 4; i++) op(0, 1, AW'(i), '0, '0, 0, 1, AW'(3 - i), '0, '0);
      repeat (3) step();

      // Saturation after 2**CNT_W+3 further collisions
      for (int i = 0; i < 11; i++) op(1, 0, 4'd9, 8'hF0, {8{8'h11}}, 1, 0, 4'd9, 8'hFF, {8{8'h22}});
      check("sat_pulse", DW'(coll_l1), 1);
      check("sat_count_l1", DW'(cnt_l1), 7);
      check("sat_count_l2", DW'(cnt_l2), 7);

      // Reset midway through the clear restarts it from address 0
      do_reset(1);
      repeat (5) begin
         check("midclear_wait", DW'(wr_l1), 1);
         step();
      end
      do_reset(1);
      wait_clear(n1, n2);
      check("reclear_cycles_l1", DW'(n1), 16);
      check("reclear_cycles_l2", DW'(n2), 16);

      // Reset with a read in flight
      wr_a(4'd9, 8'hFF, 64'h0123456789ABCDEF);
      rd_a(4'd9);
      repeat (3) step();
      op(1, 0, 4'd4, 8'hFF, 64'h5, 1, 0, 4'd4, 8'hFF, 64'h6);
      rd_a(4'd9);
      reset = 1'b1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due > cyc) sb.delete(i);
      end
      step();
      check("rst2_readdata", rd_l1 | rd_l2, 0);
      check("rst2_status", DW'({coll_l1, cnt_l1, cnt_l2}), 0);
      check("rst2_waitrequest", DW'({wr_l1, wr2_l1, busy_l1}), 3'b111);
      repeat (3) begin
         check("rst2_no_rdv", DW'({rdv_l1, rdv2_l1, rdv_l2, rdv2_l2}), 0);
         step();
      end
      reset = 1'b0;
      wait_clear(n1, n2);
      check("post_rst_clear", DW'(n1), 16);
      rd_a(4'd9);
      repeat (4) step();
      check("scoreboard_empty", DW'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_sample_ram.md
FIR_SAMPLE_RAM -- requirements
Module: fir_sample_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 14, meaning word-address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, meaning accepted-read to readdatavalid cycles; legal values are 1 and 2.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill the whole array after reset.
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning collision counter width.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high. Ports are clk (in, 1, rising-edge clock) and reset (in, 1, synchronous active-high reset).
REQ-007 Port A SHALL have these ports:
- address (in, ADDR_W)
- byteenable (in, DATA_W/8)
- chipselect (in, 1)
- read (in, 1)
- write (in, 1)
- writedata (in, DATA_W)
- readdata (out, DATA_W)
- readdatavalid (out, 1)
- waitrequest (out, 1)
REQ-008 Port B SHALL have the identical set with suffix 2: address2, byteenable2, chipselect2, read2, write2, writedata2, readdata2, readdatavalid2, waitrequest2.
REQ-009 The block SHALL have these status outputs:
- init_busy (out, 1): clear in progress.
- collision (out, 1): one-cycle same-address dual-write pulse.
- collision_count (out, CNT_W): saturating count of collision events.

Function
REQ-010 Control FSM states SHALL be CLEAR and READY; reset forces CLEAR and clear_addr=0.
REQ-011 In CLEAR with CLEAR_ON_RESET=1, the block SHALL write all-zero to clear_addr each cycle and increment it. At clear_addr=DEPTH-1 it SHALL go to READY, so the clear takes exactly DEPTH cycles.
REQ-012 In CLEAR with CLEAR_ON_RESET=0, the block SHALL go to READY on the first cycle after reset deasserts; array contents are then undefined.
REQ-013 waitrequest, waitrequest2 and init_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-014 A port SHALL accept a command when chipselect & (read|write) & ~waitrequest; non-accepted commands have no effect.
REQ-015 If read and write are both asserted on one port, the write SHALL be performed and the read ignored; no readdatavalid is generated.
REQ-016 An accepted write SHALL update byte i only where byteenable[i]=1; byteenable=0 writes nothing.
REQ-017 For an accepted read, readdatavalid SHALL be high exactly READ_LATENCY cycles later for one cycle, with readdata valid in that cycle. Back-to-back reads one per cycle SHALL be supported.
REQ-018 readdata SHALL hold its last returned value while readdatavalid=0.
REQ-019 A read accepted on cycle N SHALL return contents including all writes accepted on either port before cycle N.
REQ-020 A read on one port in the same cycle as a write on the other port to the same address SHALL return the new data: written bytes taken from the writer, remaining bytes from the old word.
REQ-021 If both ports write the same address in the same cycle:
- bytes enabled on port A SHALL take port A data;
- bytes enabled only on port B SHALL take port B data.
REQ-022 On each such same-address dual write, collision SHALL pulse 1 for one cycle. collision_count SHALL increment by 1 and saturate at 2**CNT_W-1.
REQ-023 Reads on both ports in the same cycle, to any addresses, SHALL both complete without stall.
REQ-024 Address arithmetic SHALL be unsigned; clear_addr SHALL not wrap back into CLEAR.

Reset
REQ-025 Reset SHALL take effect on the next rising clk edge and SHALL produce:
- readdata=0, readdata2=0
- readdatavalid=0, readdatavalid2=0
- collision=0, collision_count=0
- waitrequest=1, waitrequest2=1, init_busy=1
REQ-026 Reset during CLEAR SHALL restart the clear at address 0.
REQ-027 Reset SHALL drop reads in flight in READY, with no readdatavalid issued for them.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Clear after reset: ADDR_W=4, CLEAR_ON_RESET=1; release reset -> waitrequest high for exactly 16 cycles, then a read of addr 5 returns 0 with readdatavalid 1 cycle later.
- Byte-enable write: write addr 3 = 0x1122334455667788 with byteenable=0x0F over old value 0 -> a read returns 0x0000000055667788.
- Mixed-port forwarding: A writes addr 7 = 0xAA..AA (be=0xFF) while B reads addr 7 in the same cycle -> readdata2 = 0xAA..AA.
- Dual-write collision: A writes addr 9 = 0x1111111111111111 with be=0xF0 while B writes addr 9 = 0x2222222222222222 with be=0xFF -> word = 0x1111111122222222, collision pulses once, collision_count=1. Repeating 2**CNT_W+3 times leaves the count saturated.
- Read latency: READ_LATENCY=2; four back-to-back reads of addrs 0-3 -> four consecutive readdatavalid cycles, each 2 cycles after its command, data in order.
- Reset mid-operation: assert reset midway through the clear and again with a read in flight -> the clear restarts at 0 and the pending readdatavalid never asserts.
